// File: rtl/router_pkg.sv
// Shared router types: flit encoding, channel layout and VC/credit sizing used
// by every output-port controller.
package router_pkg;

    localparam int NUM_PORTS      = 5;
    localparam int NUM_VCS        = 2;
    localparam int CREDITS_PER_VC = 4;
    localparam int VCID_W         = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;
    localparam int DEST_W         = 4;
    localparam int DATA_W         = 16;

    typedef enum logic [2:0] {
        FT_I  = 3'd0,
        FT_H  = 3'd1,
        FT_B  = 3'd2,
        FT_T  = 3'd3,
        FT_HT = 3'd4
    } flit_type_t;

    typedef struct packed {
        flit_type_t          ftype;
        logic [VCID_W-1:0]   fvcid;
        logic [DEST_W-1:0]   dest;
    } head_t;

    typedef struct packed {
        head_t               head;
        logic [DATA_W-1:0]   data;
    } channel_t;

    localparam channel_t IDLE_FLIT = '{head: '{ftype: FT_I, fvcid: '0, dest: '0}, data: '0};

    function automatic logic is_head(input flit_type_t ft);
        return (ft == FT_H) || (ft == FT_HT);
    endfunction

    function automatic logic is_body(input flit_type_t ft);
        return (ft == FT_B) || (ft == FT_T);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set request at or after ptr_i, wrapping modulo N.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] idx_o,
    output logic          valid_o
);

    int unsigned pos_s;
    logic        hit_s;

    // Scan N positions starting at the pointer; the first hit wins.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        pos_s   = 32'd0;
        hit_s   = 1'b0;
        for (int k = 0; k < N; k++) begin
            pos_s          = (32'(ptr_i) + 32'(k)) % 32'(N);
            hit_s          = !valid_o && req_i[pos_s[PW-1:0]];
            gnt_o[pos_s[PW-1:0]] = gnt_o[pos_s[PW-1:0]] | hit_s;
            idx_o          = hit_s ? PW'(pos_s) : idx_o;
            valid_o        = valid_o | hit_s;
        end
    end

endmodule

// File: rtl/out_port_vc_sw_alloc.sv
// Output-port controller: switch arbitration among requesters, downstream VC
// allocation on heads held until the tail, and per-VC credit tracking.
module out_port_vc_sw_alloc
    import router_pkg::*;
#(
    parameter int NUM_REQ        = router_pkg::NUM_PORTS,
    parameter int NUM_VCS        = router_pkg::NUM_VCS,
    parameter int CREDITS_PER_VC = router_pkg::CREDITS_PER_VC
) (
    input  logic                clk,
    input  logic                arst_n,
    input  logic [NUM_REQ-1:0]  req_valid,
    input  channel_t            req_flit [NUM_REQ],
    output logic [NUM_REQ-1:0]  grant,
    output channel_t            flit_out,
    input  logic [NUM_VCS-1:0]  credits_in,
    output logic                err
);

    localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int VW = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;
    localparam int CW = $clog2(CREDITS_PER_VC + 1);
    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS_PER_VC);

    logic [NUM_VCS-1:0]  busy_q, busy_d;
    logic [RW-1:0]       owner_q    [NUM_VCS];
    logic [RW-1:0]       owner_d    [NUM_VCS];
    logic [CW-1:0]       cred_q     [NUM_VCS];
    logic [CW-1:0]       cred_d     [NUM_VCS];
    logic [NUM_REQ-1:0]  alloc_v_q, alloc_v_d;
    logic [VW-1:0]       alloc_vc_q [NUM_REQ];
    logic [VW-1:0]       alloc_vc_d [NUM_REQ];
    logic [RW-1:0]       sw_ptr_q, sw_ptr_d;
    logic [VW-1:0]       vc_ptr_q, vc_ptr_d;
    channel_t            flit_out_q, flit_out_d;
    logic                err_q, err_d;

    logic [NUM_VCS-1:0]  vc_free_s, vc_gnt_s, dec_s, ovf_s;
    logic [VW-1:0]       vc_pick_s, tgt_vc_s;
    logic                vc_any_s;
    logic [NUM_REQ-1:0]  elig_s, proto_err_s, sw_gnt_s;
    logic [RW-1:0]       win_s;
    logic                win_valid_s, win_head_s;
    channel_t            win_flit_s;

    // A VC can be handed to a new head only if it is idle and has buffer space.
    always_comb begin
        for (int v = 0; v < NUM_VCS; v++) begin
            vc_free_s[v] = !busy_q[v] && (cred_q[v] != '0);
        end
    end

    // Per-requester eligibility and protocol-violation detection.
    always_comb begin
        elig_s      = '0;
        proto_err_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig_s[i] = req_valid[i] &&
                        ((is_body(req_flit[i].head.ftype) && alloc_v_q[i] &&
                          (cred_q[alloc_vc_q[i]] != '0)) ||
                         (is_head(req_flit[i].head.ftype) && !alloc_v_q[i] && vc_any_s));
            proto_err_s[i] = req_valid[i] &&
                             ((is_body(req_flit[i].head.ftype) && !alloc_v_q[i]) ||
                              (is_head(req_flit[i].head.ftype) && alloc_v_q[i]));
        end
    end

    rr_arbiter #(.N(NUM_REQ), .PW(RW)) u_sw_arb (
        .req_i   (elig_s),
        .ptr_i   (sw_ptr_q),
        .gnt_o   (sw_gnt_s),
        .idx_o   (win_s),
        .valid_o (win_valid_s)
    );

    rr_arbiter #(.N(NUM_VCS), .PW(VW)) u_vc_arb (
        .req_i   (vc_free_s),
        .ptr_i   (vc_ptr_q),
        .gnt_o   (vc_gnt_s),
        .idx_o   (vc_pick_s),
        .valid_o (vc_any_s)
    );

    assign win_flit_s = req_flit[win_s];
    assign win_head_s = win_valid_s && is_head(win_flit_s.head.ftype);
    assign tgt_vc_s   = win_head_s ? vc_pick_s : alloc_vc_q[win_s];

    // Credit counters: return and consume on the same VC cancel out; an
    // overflowing return saturates and is flagged.
    always_comb begin
        ovf_s = '0;
        for (int v = 0; v < NUM_VCS; v++) begin
            dec_s[v] = win_valid_s &&
                       (win_head_s ? vc_gnt_s[v] : (alloc_vc_q[win_s] == VW'(v)));
            if (credits_in[v] && !dec_s[v] && (cred_q[v] == CRED_MAX)) begin
                cred_d[v] = cred_q[v];
                ovf_s[v]  = 1'b1;
            end else begin
                cred_d[v] = cred_q[v] + CW'(credits_in[v]) - CW'(dec_s[v]);
            end
        end
    end

    // Allocation, pointer and output-flit next state for the granted flit.
    always_comb begin
        busy_d     = busy_q;
        owner_d    = owner_q;
        alloc_v_d  = alloc_v_q;
        alloc_vc_d = alloc_vc_q;
        sw_ptr_d   = sw_ptr_q;
        vc_ptr_d   = vc_ptr_q;
        err_d      = err_q | (|proto_err_s) | (|ovf_s);
        flit_out_d = IDLE_FLIT;
        if (win_valid_s) begin
            sw_ptr_d = (win_s == RW'(NUM_REQ - 1)) ? '0 : win_s + 1'b1;
            flit_out_d = win_flit_s;
            flit_out_d.head.fvcid = VCID_W'(tgt_vc_s);
            if (win_head_s) begin
                vc_ptr_d = (vc_pick_s == VW'(NUM_VCS - 1)) ? '0 : vc_pick_s + 1'b1;
                owner_d[vc_pick_s] = win_s;
                // A single-flit HT packet never reserves the VC.
                if (win_flit_s.head.ftype == FT_H) begin
                    busy_d[vc_pick_s]   = 1'b1;
                    alloc_v_d[win_s]    = 1'b1;
                    alloc_vc_d[win_s]   = vc_pick_s;
                end else begin
                    alloc_v_d[win_s]    = 1'b0;
                end
            end else begin
                err_d = err_d | (owner_q[tgt_vc_s] != win_s) | !busy_q[tgt_vc_s];
                if (win_flit_s.head.ftype == FT_T) begin
                    busy_d[tgt_vc_s]    = 1'b0;
                    alloc_v_d[win_s]    = 1'b0;
                end else begin
                    busy_d[tgt_vc_s]    = 1'b1;
                end
            end
        end else begin
            flit_out_d = IDLE_FLIT;
        end
    end

    // State registers; reset drops every allocation and refills all credits.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            busy_q     <= '0;
            alloc_v_q  <= '0;
            sw_ptr_q   <= '0;
            vc_ptr_q   <= '0;
            err_q      <= 1'b0;
            flit_out_q <= IDLE_FLIT;
            for (int v = 0; v < NUM_VCS; v++) begin
                cred_q[v]  <= CRED_MAX;
                owner_q[v] <= '0;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                alloc_vc_q[i] <= '0;
            end
        end else begin
            busy_q     <= busy_d;
            alloc_v_q  <= alloc_v_d;
            sw_ptr_q   <= sw_ptr_d;
            vc_ptr_q   <= vc_ptr_d;
            err_q      <= err_d;
            flit_out_q <= flit_out_d;
            for (int v = 0; v < NUM_VCS; v++) begin
                cred_q[v]  <= cred_d[v];
                owner_q[v] <= owner_d[v];
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                alloc_vc_q[i] <= alloc_vc_d[i];
            end
        end
    end

    assign grant    = sw_gnt_s;
    assign flit_out = flit_out_q;
    assign err      = err_q;

endmodule
